// File: rtl/prbs31_checker.sv
// Serial PRBS31 (x^31 + x^28 + 1) checker: seeds from the line, hunts for a clean run,
// then flywheels its own reference and counts bit errors, dropping lock on dense errors.
module prbs31_checker #(
    parameter int LOCK_COUNT  = 32,
    parameter int WINDOW      = 256,
    parameter int LOSS_THRESH = 8,
    parameter int ERR_CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 din,
    input  logic                 clr,
    output logic                 locked,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam int WIN_W  = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int WERR_W = $clog2(WINDOW + 1);

    localparam logic [1:0] ST_SEED   = 2'd0;
    localparam logic [1:0] ST_HUNT   = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    logic [1:0]        state;
    logic [30:0]       sr;
    logic [4:0]        fill_cnt;
    logic [7:0]        run_cnt;
    logic [WIN_W-1:0]  win_cnt;
    logic [WERR_W-1:0] win_err;
    logic [WERR_W-1:0] win_err_nxt;
    logic              pred;
    logic              mism;
    logic              win_wrap;

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (&v) ? v : v + ERR_CNT_W'(1);
    endfunction

    assign pred     = sr[30] ^ sr[27];
    assign mism     = din ^ pred;
    assign win_wrap = (win_cnt == WIN_W'(WINDOW - 1));

    // The wrap bit opens the next window, so an error on it starts the new count at 1.
    always_comb begin
        win_err_nxt = win_wrap ? WERR_W'(mism) : win_err + WERR_W'(mism);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_SEED;
            sr       <= '0;
            fill_cnt <= '0;
            run_cnt  <= '0;
            win_cnt  <= '0;
            win_err  <= '0;
            locked   <= 1'b0;
            err      <= 1'b0;
        end else begin
            err <= 1'b0;
            if (en) begin
                case (state)
                    ST_SEED: begin
                        sr <= {sr[29:0], din};
                        if (fill_cnt == 5'd30) begin
                            fill_cnt <= '0;
                            state    <= ST_HUNT;
                        end else begin
                            fill_cnt <= fill_cnt + 5'd1;
                        end
                    end
                    ST_HUNT: begin
                        sr <= {sr[29:0], din};
                        if (mism) begin
                            run_cnt <= '0;
                        end else if (run_cnt == 8'(LOCK_COUNT - 1)) begin
                            run_cnt <= '0;
                            win_cnt <= '0;
                            win_err <= '0;
                            locked  <= 1'b1;
                            state   <= ST_LOCKED;
                        end else begin
                            run_cnt <= run_cnt + 8'd1;
                        end
                    end
                    ST_LOCKED: begin
                        // Flywheel on the prediction so one line error yields one err pulse.
                        sr      <= {sr[29:0], pred};
                        err     <= mism;
                        win_cnt <= win_wrap ? '0 : win_cnt + WIN_W'(1);
                        win_err <= win_err_nxt;
                        if (mism && (win_err_nxt >= WERR_W'(LOSS_THRESH))) begin
                            locked   <= 1'b0;
                            fill_cnt <= '0;
                            run_cnt  <= '0;
                            state    <= ST_SEED;
                        end
                    end
                    default: state <= ST_SEED;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (clr) begin
            err_cnt <= '0;
        end else if (en && (state == ST_LOCKED) && mism) begin
            err_cnt <= sat_inc(err_cnt);
        end
    end

endmodule
